axicb_fifo_rr_sched: RTL

//  Round-robin packet scheduler that drains NB_REQ upstream axicb_scfifo instances (STORE mode) into one

---
 rtl/axicb_fifo_rr_sched.sv | 124 ++++++++++++
 1 files changed

// File: rtl/axicb_fifo_rr_sched.sv
// Round-robin packet scheduler draining NB_REQ store-mode FIFOs
// into one registered valid/ready stream, packet-atomic.
module axicb_fifo_rr_sched #(
  parameter  int NB_REQ     = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_W       = $clog2(NB_REQ)
) (
  input  logic                         aclk,
  input  logic                         srst,
  input  logic                         en,
  input  logic [NB_REQ-1:0]            req_empty,
  input  logic [NB_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NB_REQ-1:0]            req_last,
  output logic [NB_REQ-1:0]            req_pull,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic [ID_W-1:0]              out_id,
  output logic                         busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]       grant;
  logic [ID_W-1:0]       prio_ptr;
  logic [ID_W-1:0]       grant_inc;
  logic [ID_W-1:0]       hi_idx, lo_idx;
  logic [ID_W-1:0]       pick_idx;
  logic                  hi_vld, lo_vld;
  logic                  pick_vld;
  logic                  slot_free;
  logic                  pull;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic                  sel_empty;

  // hi_* covers prio_ptr..NB_REQ-1, lo_* the wrapped part
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      if (!req_empty[i]) begin
        if (ID_W'(i) >= prio_ptr) begin
          hi_vld = 1'b1;
          hi_idx = ID_W'(i);
        end else begin
          lo_vld = 1'b1;
          lo_idx = ID_W'(i);
        end
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_empty = 1'b1;
    for (int i = 0; i < NB_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last  = req_last[i];
        sel_empty = req_empty[i];
      end
    end
  end

  assign grant_inc = (grant == ID_W'(NB_REQ - 1))
                   ? '0 : grant + 1'b1;
  assign slot_free = ~out_valid | out_ready;
  assign pull      = (state == LOCK) & slot_free
                   & ~sel_empty;

  always_ff @(posedge aclk) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (en && pick_vld) state_nxt = LOCK;
      LOCK: if (pull && sel_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_pull = '0;
    if (pull) req_pull[grant] = 1'b1;
    busy = (state == LOCK) | out_valid;
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      grant     <= '0;
      prio_ptr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
    end else begin
      if (state == IDLE && en && pick_vld)
        grant <= pick_idx;
      if (pull && sel_last)
        prio_ptr <= grant_inc;
      if (pull) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_id    <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
